// File: rtl/serv_dbg_ctrl_if.sv
// serv_dbg_ctrl_if: debug-module and core-side request/status signals for serv_dbg_ctrl
interface serv_dbg_ctrl_if;
  logic       i_haltreq;
  logic       i_resumereq;
  logic       i_ndmreset;
  logic       i_ackhavereset;
  logic       i_insn_done;
  logic       i_ebreak;
  logic       i_ebreakm;
  logic       i_step;
  logic       i_dret;
  logic       o_dbg_halt;
  logic       o_dbg_reset;
  logic       o_stall;
  logic       o_halted;
  logic       o_running;
  logic       o_resumeack;
  logic       o_havereset;
  logic [2:0] o_cause;
  modport master (
    output i_haltreq, i_resumereq, i_ndmreset, i_ackhavereset, i_insn_done,
           i_ebreak, i_ebreakm, i_step, i_dret,
    input  o_dbg_halt, o_dbg_reset, o_stall, o_halted, o_running, o_resumeack,
           o_havereset, o_cause
  );
  modport slave (
    input  i_haltreq, i_resumereq, i_ndmreset, i_ackhavereset, i_insn_done,
           i_ebreak, i_ebreakm, i_step, i_dret,
    output o_dbg_halt, o_dbg_reset, o_stall, o_halted, o_running, o_resumeack,
           o_havereset, o_cause
  );
endinterface

// File: rtl/serv_dbg_ctrl.sv
// serv_dbg_ctrl: debug-mode sequencer; halts, resumes, single-steps and resets the core on instruction boundaries
module serv_dbg_ctrl #(
  parameter int RST_CYCLES = 4
) (
  input logic             i_clk,
  input logic             i_rst,
  serv_dbg_ctrl_if.slave  dbg
);
  typedef enum logic [2:0] {RUN, HALT_PEND, HALTED, RESUME, STEP, NDMRST} state_t;
  localparam int CW = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;
  state_t        r_state, w_nxt;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_cause, w_cause;
  logic          r_dbg_halt, r_dbg_reset, r_stall, r_halted, r_running, r_resumeack, r_havereset;
  logic          w_brk;
  assign w_brk = dbg.i_insn_done & dbg.i_ebreak & dbg.i_ebreakm;
  // ebreak outranks haltreq, which outranks step, when picking the entry cause
  always_comb begin
    w_nxt   = r_state;
    w_cause = r_cause;
    case (r_state)
      RUN: begin
        if (w_brk) begin
          w_nxt   = HALTED;
          w_cause = 3'd1;
        end else if (dbg.i_haltreq) begin
          w_nxt   = dbg.i_insn_done ? HALTED : HALT_PEND;
          w_cause = dbg.i_insn_done ? 3'd3 : r_cause;
        end
      end
      HALT_PEND: if (dbg.i_insn_done) begin
        w_nxt   = HALTED;
        w_cause = w_brk ? 3'd1 : 3'd3;
      end
      HALTED: if (dbg.i_resumereq | (dbg.i_insn_done & dbg.i_dret)) begin
        w_nxt   = RESUME;
        w_cause = 3'd0;
      end
      RESUME: w_nxt = dbg.i_step ? STEP : RUN;
      STEP: if (dbg.i_insn_done) begin
        w_nxt   = HALTED;
        w_cause = w_brk ? 3'd1 : dbg.i_haltreq ? 3'd3 : 3'd4;
      end
      NDMRST: if (r_cnt == '0) w_nxt = dbg.i_haltreq ? HALT_PEND : RUN;
      default: w_nxt = RUN;
    endcase
    if (dbg.i_ndmreset) begin
      w_nxt   = NDMRST;
      w_cause = 3'd0;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= RUN;
      r_cnt       <= '0;
      r_cause     <= 3'd0;
      r_dbg_halt  <= 1'b0;
      r_dbg_reset <= 1'b0;
      r_stall     <= 1'b0;
      r_halted    <= 1'b0;
      r_running   <= 1'b1;
      r_resumeack <= 1'b0;
      r_havereset <= 1'b1;
    end else begin
      r_state     <= w_nxt;
      r_cause     <= w_cause;
      r_cnt       <= dbg.i_ndmreset ? CW'(RST_CYCLES - 1) :
                     (r_state == NDMRST && r_cnt != '0) ? r_cnt - CW'(1) : r_cnt;
      r_dbg_halt  <= w_nxt == HALTED;
      r_dbg_reset <= w_nxt == NDMRST;
      r_stall     <= w_nxt == HALT_PEND || w_nxt == HALTED || w_nxt == NDMRST;
      r_halted    <= w_nxt == HALTED;
      r_running   <= w_nxt == RUN || w_nxt == HALT_PEND || w_nxt == RESUME || w_nxt == STEP;
      r_resumeack <= w_nxt == RESUME;
      r_havereset <= dbg.i_ndmreset ? 1'b1 : dbg.i_ackhavereset ? 1'b0 : r_havereset;
    end
  end
  assign dbg.o_dbg_halt  = r_dbg_halt;
  assign dbg.o_dbg_reset = r_dbg_reset;
  assign dbg.o_stall     = r_stall;
  assign dbg.o_halted    = r_halted;
  assign dbg.o_running   = r_running;
  assign dbg.o_resumeack = r_resumeack;
  assign dbg.o_havereset = r_havereset;
  assign dbg.o_cause     = r_cause;
endmodule

// File: tb/tb_serv_dbg_ctrl.sv
// tb_serv_dbg_ctrl: vector table plus scoreboard queue, with hand-written resume and halt-latency sequences
module tb_serv_dbg_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  serv_dbg_ctrl_if d ();
  serv_dbg_ctrl #(.RST_CYCLES(4)) dut (.i_clk(clk), .i_rst(rst), .dbg(d));
  // input bits: rst hr rr ndm ack done ebk ebkm step dret
  localparam logic [9:0] NONE = 10'h000, RST = 10'h200, HR = 10'h100, RR = 10'h080,
    NDM = 10'h040, ACK = 10'h020, DONE = 10'h010, EBK = 10'h008, EBKM = 10'h004,
    STP = 10'h002, DRET = 10'h001;
  // output bits: dbg_halt dbg_reset stall halted running resumeack
  localparam logic [5:0] O_RUN = 6'b000010, O_PEND = 6'b001010, O_HALT = 6'b101100,
    O_RES = 6'b000011, O_NRST = 6'b011000;
  typedef struct {
    logic [9:0] in;
    logic [9:0] exp;
  } vec_t;
  vec_t       tv[$];
  logic [9:0] sbq[$];
  int errs = 0;
  int checks = 0;
  task automatic add(input logic [9:0] in, input logic [5:0] pat, input logic hv,
                     input logic [2:0] c, input int n = 1);
    for (int k = 0; k < n; k++) tv.push_back('{in, {pat, hv, c}});
  endtask
  task automatic drive(input logic [9:0] in);
    rst = in[9];
    d.i_haltreq = in[8];
    d.i_resumereq = in[7];
    d.i_ndmreset = in[6];
    d.i_ackhavereset = in[5];
    d.i_insn_done = in[4];
    d.i_ebreak = in[3];
    d.i_ebreakm = in[2];
    d.i_step = in[1];
    d.i_dret = in[0];
  endtask
  function automatic logic [9:0] outs();
    return {d.o_dbg_halt, d.o_dbg_reset, d.o_stall, d.o_halted, d.o_running,
            d.o_resumeack, d.o_havereset, d.o_cause};
  endfunction
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n, acks;
    logic [9:0] e;
    add(RST, O_RUN, 1, 0, 2);
    add(NONE, O_RUN, 1, 0);
    add(ACK, O_RUN, 0, 0);
    add(NONE, O_RUN, 0, 0);
    add(HR, O_PEND, 0, 0, 10);
    add(HR | DONE, O_HALT, 0, 3);
    add(NONE, O_HALT, 0, 3);
    add(HR, O_HALT, 0, 3);
    add(STP | RR, O_RES, 0, 0);
    add(STP, O_RUN, 0, 0, 4);
    add(STP | DONE, O_HALT, 0, 4);
    add(STP, O_HALT, 0, 4);
    add(RR, O_RES, 0, 0);
    add(NONE, O_RUN, 0, 0);
    add(DONE | EBK | EBKM | HR, O_HALT, 0, 1);
    add(RR, O_RES, 0, 0);
    add(NONE, O_RUN, 0, 0);
    add(DONE | EBK, O_RUN, 0, 0);
    add(DONE, O_RUN, 0, 0);
    add(HR, O_PEND, 0, 0);
    add(DONE | EBK | EBKM, O_HALT, 0, 1);
    add(NDM, O_NRST, 1, 0);
    add(NONE, O_NRST, 1, 0, 3);
    add(NONE, O_RUN, 1, 0);
    add(ACK, O_RUN, 0, 0);
    add(NDM | HR, O_NRST, 1, 0);
    add(HR, O_NRST, 1, 0, 3);
    add(HR, O_PEND, 1, 0, 2);
    add(HR | DONE, O_HALT, 1, 3);
    add(ACK | NDM, O_NRST, 1, 0);
    add(NONE, O_NRST, 1, 0, 3);
    add(NONE, O_RUN, 1, 0);
    add(ACK, O_RUN, 0, 0);
    add(NDM, O_NRST, 1, 0, 2);
    add(NONE, O_NRST, 1, 0, 3);
    add(NONE, O_RUN, 1, 0);
    add(HR | DONE, O_HALT, 1, 3);
    add(DONE | DRET, O_RES, 1, 0);
    add(NONE, O_RUN, 1, 0);
    add(DONE | DRET, O_RUN, 1, 0);
    add(HR | DONE, O_HALT, 1, 3);
    add(RR | STP, O_RES, 1, 0);
    add(STP | HR, O_RUN, 1, 0);
    add(HR | DONE | STP, O_HALT, 1, 3);
    add(RR | STP, O_RES, 1, 0);
    add(STP, O_RUN, 1, 0);
    add(DONE | EBK | EBKM | HR | STP, O_HALT, 1, 1);
    drive(RST);
    @(posedge clk); #1;
    foreach (tv[i]) begin
      drive(tv[i].in);
      sbq.push_back(tv[i].exp);
      @(posedge clk); #1;
      e = sbq.pop_front();
      check($sformatf("vec%0d", i), 32'(outs()), 32'(e));
    end
    // resumereq held for several cycles must yield a single resumeack
    acks = 0;
    drive(RR);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      acks += int'(d.o_resumeack);
    end
    check("resumeack_pulses", 32'(acks), 32'd1);
    check("running_after_resume", 32'(d.o_running), 32'd1);
    // haltreq mid-instruction: halted appears right after the retire edge
    drive(HR);
    repeat (5) begin @(posedge clk); #1; end
    check("pend_stall", 32'(d.o_stall), 32'd1);
    check("pend_not_halted", 32'(d.o_halted), 32'd0);
    drive(HR | DONE);
    @(posedge clk); #1;
    drive(NONE);
    n = 1;
    while (!d.o_halted && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check("halt_latency", 32'(n), 32'd1);
    check("halt_cause", 32'(d.o_cause), 32'd3);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/serv_dbg_ctrl.md
Name: serv_dbg_ctrl

Overview:
- Debug-mode sequencer for the bit-serial core.
- Takes halt, resume and reset requests from the debug module.
- Detects debug entry on ebreak when ebreakm is set, and on single-step completion.
- Drives the CSR block's debug-halt and debug-reset inputs and the core-stall line.
- Sits between the debug module interface and serv_csr / serv_state. All debug entry and exit happens on instruction boundaries.

Parameters:
- RST_CYCLES, 4: number of cycles `o_dbg_reset` is held after an ndmreset request (minimum 1).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_haltreq  in  1  debug module halt request (level)
- i_resumereq  in  1  debug module resume request (level)
- i_ndmreset  in  1  non-debug-module reset request (level)
- i_ackhavereset  in  1  clears havereset (pulse)
- i_insn_done  in  1  one-cycle pulse at instruction retire (cnt_done of execute phase)
- i_ebreak  in  1  retiring instruction is ebreak (qualified by i_insn_done)
- i_ebreakm  in  1  dcsr.ebreakm
- i_step  in  1  dcsr.step (o_dbg_step from CSR block)
- i_dret  in  1  retiring instruction is dret (qualified by i_insn_done)
- o_dbg_halt  out  1  to CSR i_dbg_halt; high while in debug mode
- o_dbg_reset  out  1  to CSR i_dbg_reset and core reset tree
- o_stall  out  1  holds core fetch/issue
- o_halted  out  1  status to debug module
- o_running  out  1  status to debug module
- o_resumeack  out  1  one-cycle pulse on resume accepted
- o_havereset  out  1  sticky, core has been reset
- o_cause  out  3  dcsr.cause: 1 = ebreak, 3 = haltreq, 4 = step, 0 = none

Behaviour:
- Clock and reset: single clock i_clk; i_rst is synchronous, active-high.
- Values while/after i_rst:
  - State RUN, o_cause=0, counter=0.
  - o_dbg_halt=0, o_dbg_reset=0, o_stall=0, o_halted=0, o_running=1, o_resumeack=0.
  - o_havereset=1.
- States: RUN, HALT_PEND, HALTED, RESUME, STEP, NDMRST.
- i_ndmreset: from any state, next cycle goes to NDMRST. Sets o_havereset=1 and loads counter=RST_CYCLES-1.
  - NDMRST: o_dbg_reset=1, o_stall=1. Counter decrements each cycle; at 0 go to RUN.
  - If i_haltreq is high on exit, go to HALT_PEND instead.
  - While i_ndmreset stays high, NDMRST is held and the counter is reloaded.
- RUN: o_running=1.
  - i_haltreq=1 -> HALT_PEND. The current instruction completes and is never aborted mid-serial.
  - i_insn_done & i_ebreak & i_ebreakm -> HALTED, cause=1.
- HALT_PEND: o_stall=1 blocks the next fetch; the current instruction still completes.
  - On i_insn_done (or immediately if the core is idle, signalled by i_insn_done already seen) -> HALTED.
  - Cause is 1 if that instruction was ebreak with ebreakm, else 3.
  - Same-cycle haltreq and ebreak-retire: cause=1 (ebreak > haltreq > step).
- HALTED: o_dbg_halt=1, o_stall=1, o_halted=1, o_running=0.
  - i_resumereq -> RESUME. i_haltreq is ignored while halted.
- RESUME: exactly one cycle with o_resumeack=1, o_stall=0, o_dbg_halt=0, cause cleared to 0.
  - Then STEP if i_step=1, else RUN.
- STEP: o_running=1, o_stall=0. Exactly one instruction executes.
  - On i_insn_done -> HALTED.
  - Cause=1 if ebreak&ebreakm, else 3 if i_haltreq, else 4.
- o_cause holds its value from debug entry until RESUME.
- i_dret: causes a transition only when retired inside HALTED program-buffer execution. The core is stalled, so i_dret is treated as resumereq.
- i_ackhavereset clears o_havereset one cycle later. It loses to a simultaneous i_ndmreset (stays 1).
- All outputs are registered; state decode to outputs has no combinational path from inputs, except o_stall in HALT_PEND, which is registered on entry.
- Latency:
  - haltreq to halted: the remaining cycles of the current instruction + 1.
  - resumereq to resumeack: 1 cycle.

Test Plan:
- Reset, then i_ackhavereset pulse -> o_havereset 1 then 0 one cycle later; o_running=1, o_cause=0.
- RUN, raise i_haltreq mid-instruction, i_insn_done 10 cycles later -> o_halted=1 the cycle after i_insn_done, o_cause=3, o_dbg_halt=1, o_stall=1.
- Halted, i_step=1, i_resumereq -> o_resumeack single pulse. After the next i_insn_done -> o_halted=1, o_cause=4; no second instruction issued.
- RUN, i_insn_done with i_ebreak=1, i_ebreakm=1 and i_haltreq=1 same cycle -> HALTED with o_cause=1. With i_ebreakm=0 and no haltreq -> stays RUN.
- RST_CYCLES=4, pulse i_ndmreset while HALTED -> o_dbg_reset high exactly 4 cycles, o_havereset=1, then RUN (or HALT_PEND if i_haltreq held, halting with cause 3 at the first i_insn_done).
- i_ackhavereset and i_ndmreset in the same cycle -> o_havereset remains 1.
